// File: rtl/count_cycle_gen.sv
// count_cycle_gen: tags AXI-Stream beats with a frame position (up/down) and a final flag,
// using a split-carry counter, two pipeline stages and an output FIFO. Option: COUNT_CYCLE_FRAME_ID_EN.
module count_cycle_gen #(
  parameter int DATA_WIDTH      = 32,
  parameter int CNT_WIDTH       = 16,
  parameter int FIFO_ADDR_WIDTH = 3,
  parameter int FRAME_ID_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      sync_reset,
  input  logic                      s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  output logic                      s_axis_tready,
  input  logic [CNT_WIDTH-1:0]      cnt_limit,
  input  logic                      cnt_up,
  output logic                      m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [CNT_WIDTH-1:0]      m_axis_count,
  output logic                      m_axis_final_cnt,
  output logic [FRAME_ID_WIDTH-1:0] m_axis_frame_id,
  input  logic                      m_axis_tready
);
  localparam int LO_W   = CNT_WIDTH / 2;
  localparam int HI_W   = CNT_WIDTH - LO_W;
  localparam int DEPTH  = 1 << FIFO_ADDR_WIDTH;
  localparam int BASE_W = 1 + CNT_WIDTH + DATA_WIDTH;
`ifdef COUNT_CYCLE_FRAME_ID_EN
  localparam int WORD_W = FRAME_ID_WIDTH + BASE_W;
`else
  localparam int WORD_W = BASE_W;
`endif
  localparam logic [LO_W:0]            LO_ONE = (LO_W+1)'(1);
  localparam logic [FIFO_ADDR_WIDTH:0] AFULL  = (FIFO_ADDR_WIDTH+1)'(DEPTH - 3);

  typedef enum logic {ST_START, ST_RUN} state_t;

  state_t               state_q;
  logic                 up_q;
  logic [CNT_WIDTH-1:0] lim_q;
  logic [LO_W-1:0]      lo_q;
  logic [HI_W-1:0]      hi_q;
  logic                 pend_q;

  logic                 accept;
  logic                 beat_up;
  logic [CNT_WIDTH-1:0] beat_lim;
  logic [LO_W-1:0]      beat_lo;
  logic [HI_W-1:0]      beat_hi_raw;
  logic                 beat_pend;
  logic [HI_W-1:0]      beat_hi;
  logic                 beat_final;
  logic [LO_W-1:0]      lo_next;
  logic                 lo_carry;

  assign accept = s_axis_tvalid & s_axis_tready & ~sync_reset;

  // The high half lags by one cycle: pend_q holds the low-half carry/borrow not yet folded in.
  always_comb begin
    if (state_q == ST_START) begin
      beat_up     = cnt_up;
      beat_lim    = cnt_limit;
      beat_lo     = cnt_up ? '0 : cnt_limit[LO_W-1:0];
      beat_hi_raw = cnt_up ? '0 : cnt_limit[CNT_WIDTH-1:LO_W];
      beat_pend   = 1'b0;
    end else begin
      beat_up     = up_q;
      beat_lim    = lim_q;
      beat_lo     = lo_q;
      beat_hi_raw = hi_q;
      beat_pend   = pend_q;
    end
    beat_hi    = beat_up ? beat_hi_raw + HI_W'(beat_pend) : beat_hi_raw - HI_W'(beat_pend);
    beat_final = beat_up ? ({beat_hi, beat_lo} == beat_lim) : ({beat_hi, beat_lo} == '0);
    {lo_carry, lo_next} = beat_up ? {1'b0, beat_lo} + LO_ONE : {1'b0, beat_lo} - LO_ONE;
  end

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      state_q <= ST_START;
      up_q    <= 1'b0;
      lim_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      pend_q  <= 1'b0;
    end else if (accept) begin
      lo_q    <= lo_next;
      hi_q    <= beat_hi;
      pend_q  <= lo_carry;
      if (state_q == ST_START) begin
        lim_q <= cnt_limit;
        up_q  <= cnt_up;
      end
      state_q <= beat_final ? ST_START : ST_RUN;
    end else begin
      hi_q   <= up_q ? hi_q + HI_W'(pend_q) : hi_q - HI_W'(pend_q);
      pend_q <= 1'b0;
    end
  end

  logic [WORD_W-1:0] s1_word_d;
`ifdef COUNT_CYCLE_FRAME_ID_EN
  logic [FRAME_ID_WIDTH-1:0] frame_q;
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset)
      frame_q <= '0;
    else if (accept && beat_final)
      frame_q <= frame_q + 1'b1;
  end
  assign s1_word_d = {frame_q, beat_final, beat_hi, beat_lo, s_axis_tdata};
`else
  assign s1_word_d = {beat_final, beat_hi, beat_lo, s_axis_tdata};
`endif

  logic              s1_valid_q, s2_valid_q;
  logic [WORD_W-1:0] s1_word_q, s2_word_q;

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      s1_valid_q <= 1'b0;
      s1_word_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_word_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      s1_word_q  <= s1_word_d;
      s2_valid_q <= s1_valid_q;
      s2_word_q  <= s1_word_q;
    end
  end

  // Output register is part of the FIFO; it is refilled from memory, or from stage 2 when memory is empty.
  logic [WORD_W-1:0]          mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_ADDR_WIDTH:0]   mem_cnt_q;
  logic [FIFO_ADDR_WIDTH:0]   inflight_q;
  logic                       out_valid_q;
  logic [WORD_W-1:0]          out_word_q;
  logic                       pop, load_out, mem_rd, bypass, mem_wr;

  assign pop      = out_valid_q & m_axis_tready;
  assign load_out = ~out_valid_q | pop;
  assign mem_rd   = load_out & (mem_cnt_q != '0);
  assign bypass   = load_out & (mem_cnt_q == '0) & s2_valid_q;
  assign mem_wr   = s2_valid_q & ~bypass;

  always_ff @(posedge clk) begin
    if (mem_wr)
      mem[wr_ptr_q] <= s2_word_q;
  end

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      inflight_q  <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else begin
      if (mem_wr)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (mem_rd)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      if (mem_wr && !mem_rd)
        mem_cnt_q <= mem_cnt_q + 1'b1;
      else if (!mem_wr && mem_rd)
        mem_cnt_q <= mem_cnt_q - 1'b1;
      if (accept && !pop)
        inflight_q <= inflight_q + 1'b1;
      else if (!accept && pop)
        inflight_q <= inflight_q - 1'b1;
      if (load_out) begin
        if (mem_rd) begin
          out_valid_q <= 1'b1;
          out_word_q  <= mem[rd_ptr_q];
        end else if (bypass) begin
          out_valid_q <= 1'b1;
          out_word_q  <= s2_word_q;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  // inflight_q counts every beat from accept to emit, so the FIFO can never be overrun.
  assign s_axis_tready    = inflight_q < AFULL;
  assign m_axis_tvalid    = out_valid_q;
  assign m_axis_tdata     = out_word_q[DATA_WIDTH-1:0];
  assign m_axis_count     = out_word_q[DATA_WIDTH +: CNT_WIDTH];
  assign m_axis_final_cnt = out_word_q[DATA_WIDTH + CNT_WIDTH];
`ifdef COUNT_CYCLE_FRAME_ID_EN
  assign m_axis_frame_id  = out_word_q[WORD_W-1 -: FRAME_ID_WIDTH];
`else
  assign m_axis_frame_id  = '0;
`endif
endmodule

// File: tb/tb_count_cycle_gen.sv
// Bench for count_cycle_gen: frame-position model with a per-cycle compare process,
// plus directed sequences pinned by literal expectations.
`timescale 1ns/1ps
module tb_count_cycle_gen;
  localparam int DW = 32, CW = 16, AW = 3, FW = 8;

  logic          clk = 1'b0;
  logic          sync_reset = 1'b1;
  logic          s_axis_tvalid = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tready;
  logic [CW-1:0] cnt_limit = '0;
  logic          cnt_up = 1'b0;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic [CW-1:0] m_axis_count;
  logic          m_axis_final_cnt;
  logic [FW-1:0] m_axis_frame_id;
  logic          m_axis_tready = 1'b1;

  count_cycle_gen #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .FIFO_ADDR_WIDTH(AW), .FRAME_ID_WIDTH(FW)) dut (
    .clk(clk), .sync_reset(sync_reset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tready(s_axis_tready),
    .cnt_limit(cnt_limit), .cnt_up(cnt_up),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_count(m_axis_count),
    .m_axis_final_cnt(m_axis_final_cnt), .m_axis_frame_id(m_axis_frame_id),
    .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

`ifdef COUNT_CYCLE_FRAME_ID_EN
  localparam bit FID_ON = 1'b1;
`else
  localparam bit FID_ON = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
    logic          fin;
    logic [FW-1:0] fid;
  } beat_t;

  // Model: a beat's count follows from its index within the frame and the frame's captured settings.
  beat_t  exp_q[$];
  bit     frame_open = 1'b0;
  longint f_lim = 0;
  bit     f_up = 1'b0;
  longint f_idx = 0;
  int     fid_m = 0;
  int     outstanding = 0;
  int     cyc = 0;
  int     first_acc = -1;
  int     first_vld = -1;
  int     got_cnt[$];
  int     got_fin[$];
  int     got_fid[$];
  bit     prev_stall = 1'b0;
  beat_t  prev_out;
  bit     rnd_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : compare
    beat_t e;
    beat_t n;
    if (sync_reset) begin
      exp_q.delete();
      frame_open = 1'b0;
      fid_m = 0;
      outstanding = 0;
      prev_stall = 1'b0;
    end else begin
      check("s_axis_tready", s_axis_tready, outstanding < 5);
      if (prev_stall) begin
        check("stall_tvalid", m_axis_tvalid, 1);
        check("stall_tdata", m_axis_tdata, prev_out.data);
        check("stall_count", m_axis_count, prev_out.cnt);
        check("stall_final", m_axis_final_cnt, prev_out.fin);
        check("stall_fid", m_axis_frame_id, prev_out.fid);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_tdata", m_axis_tdata, e.data);
          check("out_count", m_axis_count, e.cnt);
          check("out_final", m_axis_final_cnt, e.fin);
          check("out_frame_id", m_axis_frame_id, e.fid);
        end
        got_cnt.push_back(int'(m_axis_count));
        got_fin.push_back(int'(m_axis_final_cnt));
        got_fid.push_back(int'(m_axis_frame_id));
        $display("beat data=%08h count=%0d final=%0d frame_id=%0d",
                 m_axis_tdata, m_axis_count, m_axis_final_cnt, m_axis_frame_id);
        outstanding--;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        if (!frame_open) begin
          f_lim = longint'(cnt_limit);
          f_up = cnt_up;
          f_idx = 0;
          frame_open = 1'b1;
        end
        n.data = s_axis_tdata;
        n.cnt  = CW'(f_up ? f_idx : f_lim - f_idx);
        n.fin  = (f_idx == f_lim);
        n.fid  = FID_ON ? FW'(fid_m) : '0;
        f_idx++;
        if (n.fin) begin
          frame_open = 1'b0;
          fid_m++;
        end
        exp_q.push_back(n);
        outstanding++;
        if (first_acc < 0) first_acc = cyc;
      end
      if (m_axis_tvalid && first_vld < 0) first_vld = cyc;
      prev_stall    = m_axis_tvalid && !m_axis_tready;
      prev_out.data = m_axis_tdata;
      prev_out.cnt  = m_axis_count;
      prev_out.fin  = m_axis_final_cnt;
      prev_out.fid  = m_axis_frame_id;
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] data);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_axis_tready && !sync_reset;
      @(posedge clk);
      #1;
      n++;
    end
    check("send_accepted", acc, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
    tick();
    tick();
  endtask

  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    sync_reset = 1'b1;
    tick();
    tick();
    sync_reset = 1'b0;
  endtask

  task automatic clear_logs();
    got_cnt.delete();
    got_fin.delete();
    got_fid.delete();
  endtask

  int exp_down[8] = '{3, 2, 1, 0, 3, 2, 1, 0};
  int exp_up[9]   = '{0, 1, 2, 0, 1, 2, 3, 4, 5};

  initial begin : stim
    int acc_cnt;
    bit acc;
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_count", m_axis_count, 0);
    check("rst_final", m_axis_final_cnt, 0);
    check("rst_frame_id", m_axis_frame_id, 0);
    tick();
    sync_reset = 1'b0;
    #1;
    check("rst_s_tready", s_axis_tready, 1);

    // Down-count, limit 3, continuous
    clear_logs();
    first_acc = -1;
    first_vld = -1;
    cnt_limit = 16'd3;
    cnt_up = 1'b0;
    for (int i = 0; i < 8; i++) send(32'hA000_0000 + 32'(i));
    s_axis_tvalid = 1'b0;
    drain();
    check("t1_latency", first_vld - first_acc, 3);
    check("t1_beats", got_cnt.size(), 8);
    for (int i = 0; i < 8 && i < got_cnt.size(); i++) begin
      check("t1_count", got_cnt[i], exp_down[i]);
      check("t1_final", got_fin[i], (i == 3 || i == 7) ? 1 : 0);
    end

    // Up-count, limit changed mid-frame
    clear_logs();
    cnt_limit = 16'd2;
    cnt_up = 1'b1;
    send(32'hB000_0000);
    cnt_limit = 16'd5;
    for (int i = 1; i < 9; i++) send(32'hB000_0000 + 32'(i));
    s_axis_tvalid = 1'b0;
    drain();
    check("t2_beats", got_cnt.size(), 9);
    for (int i = 0; i < 9 && i < got_cnt.size(); i++) begin
      check("t2_count", got_cnt[i], exp_up[i]);
      check("t2_final", got_fin[i], (i == 2 || i == 8) ? 1 : 0);
    end

    // Limit 0: every beat final
    do_reset();
    clear_logs();
    cnt_limit = 16'd0;
    cnt_up = 1'b0;
    for (int i = 0; i < 4; i++) send(32'hC000_0000 + 32'(i));
    s_axis_tvalid = 1'b0;
    drain();
    check("t3_beats", got_cnt.size(), 4);
    for (int i = 0; i < 4 && i < got_cnt.size(); i++) begin
      check("t3_count", got_cnt[i], 0);
      check("t3_final", got_fin[i], 1);
      check("t3_frame_id", got_fid[i], FID_ON ? i : 0);
    end

    // Backpressure
    clear_logs();
    cnt_limit = 16'd3;
    cnt_up = 1'b0;
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'hD000_0000;
    acc_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      if (acc) begin
        acc_cnt++;
        s_axis_tdata = s_axis_tdata + 32'd1;
      end
    end
    check("t4_accepts", acc_cnt, 5);
    check("t4_s_tready_low", s_axis_tready, 0);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) send(32'hD100_0000 + 32'(i));
    s_axis_tvalid = 1'b0;
    drain();
    check("t4_beats", got_cnt.size(), 8);
    for (int i = 0; i < 8 && i < got_cnt.size(); i++)
      check("t4_count", got_cnt[i], exp_down[i]);

    // Random handshakes, limit 300: one up frame then one down frame
    clear_logs();
    cnt_limit = 16'd300;
    cnt_up = 1'b1;
    rnd_ready = 1'b1;
    for (int i = 0; i < 602; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        s_axis_tvalid = 1'b0;
        tick();
      end
      send(32'(i) ^ 32'h5A5A_0000);
      if (i == 0) cnt_up = 1'b0;
    end
    s_axis_tvalid = 1'b0;
    rnd_ready = 1'b0;
    #0;
    m_axis_tready = 1'b1;
    drain();
    check("t5_beats", got_cnt.size(), 602);
    if (got_cnt.size() == 602) begin
      check("t5_up_255", got_cnt[255], 255);
      check("t5_up_256", got_cnt[256], 256);
      check("t5_up_final", got_fin[300], 1);
      check("t5_down_first", got_cnt[301], 300);
      check("t5_down_256", got_cnt[345], 256);
      check("t5_down_255", got_cnt[346], 255);
      check("t5_down_final", got_fin[601], 1);
    end

    // Reset mid-frame with beats buffered
    cnt_limit = 16'd10;
    cnt_up = 1'b0;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'hE000_0000 + 32'(i));
    s_axis_tvalid = 1'b0;
    tick();
    tick();
    tick();
    check("t6_buffered_valid", m_axis_tvalid, 1);
    sync_reset = 1'b1;
    #1;
    check("t6_rst_tvalid", m_axis_tvalid, 0);
    check("t6_rst_tdata", m_axis_tdata, 0);
    check("t6_rst_count", m_axis_count, 0);
    check("t6_rst_final", m_axis_final_cnt, 0);
    check("t6_rst_frame_id", m_axis_frame_id, 0);
    tick();
    tick();
    sync_reset = 1'b0;
    clear_logs();
    cnt_limit = 16'd7;
    m_axis_tready = 1'b1;
    send(32'hF000_0000);
    s_axis_tvalid = 1'b0;
    drain();
    check("t6_beats", got_cnt.size(), 1);
    if (got_cnt.size() > 0) begin
      check("t6_first_count", got_cnt[0], 7);
      check("t6_first_fid", got_fid[0], 0);
      check("t6_first_final", got_fin[0], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
